// File: rtl/pi_key_capture_pkg.sv
// Shared constants for the key-capture PIO: register word addresses and
// edge-selection encodings.
package pi_key_capture_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pi_debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a stable-count debouncer.
// update/new_value strobe the cycle whose clk edge will change stable.
module pi_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic stable,
  output logic update,
  output logic new_value
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;

  assign update    = (sync2 != stable) && (count == CNT_LAST);
  assign new_value = sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      count  <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= in_bit;
      sync2 <= sync1;
      // Any return to the stable level restarts the count, rejecting short glitches.
      if (sync2 == stable) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        stable <= sync2;
        count  <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pi_key_capture.sv
// Avalon-MM input PIO: debounced key/switch inputs, sticky edge capture
// with write-1-to-clear, maskable level interrupt.
module pi_key_capture
  import pi_key_capture_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] new_value;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clear_mask;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign in_x = (ACTIVE_LOW != 0) ? ~in_port : in_port;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pi_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_bit   (in_x[i]),
      .stable   (stable[i]),
      .update   (update[i]),
      .new_value(new_value[i])
    );
  end

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_pulse = update & ~new_value;
      EDGE_ANY:  edge_pulse = update;
      default:   edge_pulse = update & new_value;
    endcase
  end

  assign wr_en        = chipselect && !write_n;
  assign clear_mask   = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0] = stable;
      ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP:  rd_mux[WIDTH-1:0] = edgecapture;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask    <= '0;
      edgecapture <= '0;
      readdata    <= '0;
    end else begin
      if (wr_en && (address == ADDR_IRQ_MASK)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      // OR-ing the new pulses after the clear makes a same-cycle set win.
      edgecapture <= (edgecapture & ~clear_mask) | edge_pulse;
      readdata    <= rd_mux;
    end
  end

  assign irq = |(edgecapture & irq_mask);

endmodule

// File: tb/tb_pi_key_capture.sv
// Randomized plus directed bench for pi_key_capture: three instances (rise,
// fall, both edges) checked every cycle against a pin-history reference model.
module tb_pi_key_capture;
  import pi_key_capture_pkg::*;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  in_port;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   rd [NI];
  logic [NI-1:0] irq_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pi_key_capture #(
      .WIDTH(W),
      .DEBOUNCE_CYCLES(D),
      .ACTIVE_LOW(1),
      .EDGE_TYPE(g)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_port   (in_port),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (rd[g]),
      .irq       (irq_v[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: hist holds the conditioned pin value seen at each clk edge
  // since reset release; a bit's level is accepted once the pin value from two
  // edges earlier has disagreed with the accepted level for D edges in a row.
  logic [W-1:0]  hist [$];
  logic [W-1:0]  st_m;
  logic [W-1:0]  mask_m;
  logic [W-1:0]  ec_m [NI];
  logic [31:0]   rd_m [NI];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic pin_at(int edge_no, int b);
    int idx;
    idx = edge_no - 3;
    if (idx < 0) return 1'b0;
    return hist[idx][b];
  endfunction

  task automatic model_reset();
    hist.delete();
    st_m   = '0;
    mask_m = '0;
    for (int g = 0; g < NI; g++) begin
      ec_m[g] = '0;
      rd_m[g] = '0;
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] flip;
    logic [W-1:0] pulse;
    logic [W-1:0] clr;
    logic         wr;
    logic         newv;
    int           k;
    hist.push_back(~in_port);
    k = hist.size();
    for (int b = 0; b < W; b++) begin
      flip[b] = 1'b1;
      for (int j = 0; j < D; j++)
        if (pin_at(k - j, b) == st_m[b]) flip[b] = 1'b0;
    end
    wr  = chipselect && !write_n;
    clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int g = 0; g < NI; g++) begin
      case (address)
        2'd0:    rd_m[g] = 32'(st_m);
        2'd2:    rd_m[g] = 32'(mask_m);
        2'd3:    rd_m[g] = 32'(ec_m[g]);
        default: rd_m[g] = 32'h0;
      endcase
      for (int b = 0; b < W; b++) begin
        newv     = ~st_m[b];
        pulse[b] = flip[b] && (g == EDGE_ANY || (g == EDGE_RISE && newv) || (g == EDGE_FALL && !newv));
      end
      ec_m[g] = (ec_m[g] & ~clr) | pulse;
    end
    if (wr && address == 2'd2) mask_m = writedata[W-1:0];
    st_m = st_m ^ flip;
  endtask

  task automatic check_outputs();
    for (int g = 0; g < NI; g++) begin
      check_eq($sformatf("readdata[%0d]", g), rd[g], rd_m[g]);
      check_eq($sformatf("irq[%0d]", g), {31'b0, irq_v[g]}, {31'b0, |(ec_m[g] & mask_m)});
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = $urandom;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_port    = 4'b1110;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;

    // Key0 held through reset release.
    tick(6);
    check_eq("s1_data_before", rd[0], 32'h0);
    tick(1);
    check_eq("s1_data_after", rd[0], 32'h1);
    address = 2'd3;
    tick(1);
    check_eq("s1_edgecap", rd[0], 32'h1);
    check_eq("s1_irq_masked", {31'b0, irq_v[0]}, 32'h0);

    // Glitch rejection then an accepted 4-cycle pulse on key1.
    in_port = 4'b1100;
    tick(3);
    in_port = 4'b1110;
    tick(10);
    address = 2'd0;
    tick(1);
    check_eq("s2_glitch_data", rd[0], 32'h1);
    in_port = 4'b1100;
    tick(4);
    in_port = 4'b1110;
    tick(3);
    check_eq("s2_pulse_data", rd[0], 32'h3);
    tick(8);

    // IRQ path through mask and write-1-to-clear.
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h2);
    address = 2'd3;
    in_port = 4'b1100;
    tick(5);
    check_eq("s3_irq_pre", {31'b0, irq_v[0]}, 32'h0);
    tick(1);
    check_eq("s3_irq_set", {31'b0, irq_v[0]}, 32'h1);
    bus_write(2'd3, 32'h2);
    check_eq("s3_irq_clr", {31'b0, irq_v[0]}, 32'h0);
    tick(1);
    check_eq("s3_edgecap_clr", rd[0], 32'h0);

    // Clear of bit2 lands on the edge a new bit2 edge is accepted.
    in_port = 4'b1000;
    tick(5);
    bus_write(2'd3, 32'h4);
    tick(1);
    check_eq("s4_collide", rd[0], 32'h4);

    // Press then release key3 across edge types, reserved address.
    in_port = 4'b0000;
    tick(7);
    bus_write(2'd3, 32'hF);
    in_port = 4'b1000;
    tick(7);
    check_eq("s5_rise_release", rd[0], 32'h0);
    check_eq("s5_fall_release", rd[1], 32'h8);
    check_eq("s5_any_release", rd[2], 32'h8);
    address = 2'd1;
    tick(1);
    for (int g = 0; g < NI; g++) check_eq($sformatf("s5_reserved[%0d]", g), rd[g], 32'h0);

    // Reset while key0's debounce count is partway.
    in_port = 4'b1111;
    tick(8);
    in_port = 4'b1110;
    tick(4);
    do_reset();
    address = 2'd0;
    tick(6);
    check_eq("s6_data_before", rd[0], 32'h0);
    tick(1);
    check_eq("s6_data_after", rd[0], 32'h1);

    // Random pin activity with random bus traffic.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) in_port = 4'($urandom);
      if (it == 150) begin
        do_reset();
      end else if ($urandom_range(0, 3) == 0) begin
        bus_write(2'($urandom), $urandom);
      end else begin
        address    = 2'($urandom);
        chipselect = 1'($urandom);
      end
      tick($urandom_range(1, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
